// File: rtl/conv_window_sched.sv
// Sliding-window scheduler: fetches a KxK window from image BRAM into the window registers,
// runs the convolution engine once per output pixel and writes each result to the result BRAM.
// Optional macro CONV_SCHED_RELU_EN clamps negative (signed) results to zero before the write.
module conv_window_sched #(
    parameter int IMG_W           = 28,
    parameter int IMG_H           = 28,
    parameter int KERNEL_SIZE     = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int WIN_ADDR_WIDTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_abort,
    output logic [BRAM_ADDR_WIDTH-1:0] o_bram_rd_addr,
    input  logic [DATA_WIDTH-1:0]      i_bram_rd_data,
    output logic                       o_win_wr_en,
    output logic [WIN_ADDR_WIDTH-1:0]  o_win_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_win_wr_data,
    output logic                       o_conv_start,
    input  logic                       i_conv_done,
    input  logic [DATA_WIDTH-1:0]      i_conv_result,
    output logic                       o_res_wr_en,
    output logic [BRAM_ADDR_WIDTH-1:0] o_res_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_res_wr_data,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam int CW = 16;
    localparam logic [CW-1:0] K_L     = CW'(KERNEL_SIZE);
    localparam logic [CW-1:0] KK_L    = CW'(KERNEL_SIZE * KERNEL_SIZE);
    localparam logic [CW-1:0] OUT_W_L = CW'(IMG_W - KERNEL_SIZE + 1);
    localparam logic [CW-1:0] OUT_H_L = CW'(IMG_H - KERNEL_SIZE + 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_CONV, WRITE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             row_q, row_d, col_q, col_d;
    logic [CW-1:0]             kx_q, kx_d, ky_q, ky_d;
    logic [CW-1:0]             fcnt_q, fcnt_d;
    logic                      win_wr_en_q, win_wr_en_d;
    logic [WIN_ADDR_WIDTH-1:0] win_idx_q, win_idx_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic [DATA_WIDTH-1:0]     res_val;
    logic                      reading;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        kx_d         = kx_q;
        ky_d         = ky_q;
        fcnt_d       = fcnt_q;
        win_wr_en_d  = 1'b0;
        win_idx_d    = win_idx_q;
        result_d     = result_q;
        reading      = 1'b0;
        o_conv_start = 1'b0;
        o_res_wr_en  = 1'b0;
        o_done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    row_d   = '0;
                    col_d   = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    fcnt_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // One read per cycle; the final FETCH cycle only lands the last pixel.
                if (fcnt_q < KK_L) begin
                    reading     = 1'b1;
                    win_wr_en_d = 1'b1;
                    win_idx_d   = WIN_ADDR_WIDTH'(fcnt_q);
                    fcnt_d      = fcnt_q + 16'd1;
                    if (kx_q == K_L - 16'd1) begin
                        kx_d = '0;
                        ky_d = ky_q + 16'd1;
                    end else begin
                        kx_d = kx_q + 16'd1;
                    end
                end else begin
                    state_d = START;
                end
            end
            START: begin
                o_conv_start = 1'b1;
                state_d      = WAIT_CONV;
            end
            WAIT_CONV: begin
                if (i_conv_done) begin
                    result_d = i_conv_result;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                o_res_wr_en = 1'b1;
                kx_d        = '0;
                ky_d        = '0;
                fcnt_d      = '0;
                state_d     = FETCH;
                if (col_q == OUT_W_L - 16'd1) begin
                    col_d = '0;
                    if (row_q == OUT_H_L - 16'd1) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 16'd1;
                    end
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_abort) begin
            state_d      = IDLE;
            win_wr_en_d  = 1'b0;
            o_conv_start = 1'b0;
            o_res_wr_en  = 1'b0;
            o_done       = 1'b0;
        end
    end

`ifdef CONV_SCHED_RELU_EN
    assign res_val = result_q[DATA_WIDTH-1] ? '0 : result_q;
`else
    assign res_val = result_q;
`endif

    // Address and data buses are forced to zero whenever their strobe is low.
    assign o_bram_rd_addr = reading ?
        BRAM_ADDR_WIDTH'(row_q + ky_q) * BRAM_ADDR_WIDTH'(IMG_W) + BRAM_ADDR_WIDTH'(col_q + kx_q) : '0;
    assign o_res_wr_addr  = o_res_wr_en ?
        BRAM_ADDR_WIDTH'(row_q) * BRAM_ADDR_WIDTH'(OUT_W_L) + BRAM_ADDR_WIDTH'(col_q) : '0;
    assign o_res_wr_data  = o_res_wr_en ? res_val : '0;
    assign o_win_wr_en    = win_wr_en_q;
    assign o_win_wr_addr  = win_wr_en_q ? win_idx_q : '0;
    assign o_win_wr_data  = win_wr_en_q ? i_bram_rd_data : '0;
    assign o_busy         = (state_q != IDLE);

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            fcnt_q      <= '0;
            win_wr_en_q <= 1'b0;
            win_idx_q   <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            fcnt_q      <= fcnt_d;
            win_wr_en_q <= win_wr_en_d;
            win_idx_q   <= win_idx_d;
            result_q    <= result_d;
        end
    end
endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: image BRAM model p[a]=a mod 256, engine stub with
// 3-cycle done latency; expected window/result writes are queued and checked by a monitor.
module tb_conv_window_sched;
    typedef struct {
        logic [3:0] idx;
        logic [9:0] rd_addr;
        logic [7:0] data;
    } win_t;
    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } res_t;

    logic       clk = 1'b0;
    logic       rst, start, abort, stray_done;
    logic [9:0] bram_rd_addr;
    logic [7:0] bram_q;
    logic       win_wr_en;
    logic [3:0] win_wr_addr;
    logic [7:0] win_wr_data;
    logic       conv_start, conv_done;
    logic [7:0] stub_res;
    logic [1:0] stub_cnt;
    logic       res_wr_en;
    logic [9:0] res_wr_addr;
    logic [7:0] res_wr_data;
    logic       busy, done;
    logic [7:0] win0_q;

    win_t win_exp[$];
    res_t res_exp[$];
    logic [7:0] stub_q[$];

    int n_total = 0, n_bad = 0;
    int cyc = 0;
    int res_cnt = 0, done_cnt = 0, conv_start_cnt = 0, conv_start_cyc = 0;
    logic [9:0] rd_prev = '0, last_base = '0;

    always #5 clk = ~clk;

    conv_window_sched dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_bram_rd_addr(bram_rd_addr), .i_bram_rd_data(bram_q),
        .o_win_wr_en(win_wr_en), .o_win_wr_addr(win_wr_addr), .o_win_wr_data(win_wr_data),
        .o_conv_start(conv_start), .i_conv_done(conv_done), .i_conv_result(stub_res),
        .o_res_wr_en(res_wr_en), .o_res_wr_addr(res_wr_addr), .o_res_wr_data(res_wr_data),
        .o_busy(busy), .o_done(done)
    );

    function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef CONV_SCHED_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bram_q <= bram_rd_addr[7:0];
    always @(posedge clk) if (win_wr_en && win_wr_addr == 4'd0) win0_q <= win_wr_data;

    // Engine stub: done (and result) three cycles after the start pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt <= 2'd0;
            stub_res <= 8'd0;
        end else if (conv_start) begin
            stub_cnt <= 2'd3;
            if (stub_q.size() > 0) stub_res <= stub_q.pop_front();
            else stub_res <= win0_q;
        end else if (stub_cnt != 2'd0) begin
            stub_cnt <= stub_cnt - 2'd1;
        end
    end
    assign conv_done = (stub_cnt == 2'd1) | stray_done;

    // Monitor: compares every presented write against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (res_wr_en) begin
                res_cnt++;
                if (res_exp.size() == 0) begin
                    check("res_extra_write", 32'(res_wr_addr), 32'hFFFF_FFFF);
                end else begin
                    res_t e;
                    e = res_exp.pop_front();
                    check("res_addr", 32'(res_wr_addr), 32'(e.addr));
                    check("res_data", 32'(res_wr_data), 32'(e.data));
                end
            end
            if (win_wr_en) begin
                if (win_wr_addr == 4'd0) last_base = rd_prev;
                if (win_exp.size() > 0) begin
                    win_t w;
                    w = win_exp.pop_front();
                    check("win_idx", 32'(win_wr_addr), 32'(w.idx));
                    check("win_data", 32'(win_wr_data), 32'(w.data));
                    check("rd_addr", 32'(rd_prev), 32'(w.rd_addr));
                end
            end
            if (done) done_cnt++;
            if (conv_start) begin
                conv_start_cnt++;
                conv_start_cyc = cyc;
            end
            rd_prev = bram_rd_addr;
        end
    end

    task automatic push_first_window();
        for (int i = 0; i < 9; i++) begin
            win_t w;
            w.idx     = 4'(i);
            w.rd_addr = 10'((i / 3) * 28 + (i % 3));
            w.data    = 8'(w.rd_addr);
            win_exp.push_back(w);
        end
    endtask

    task automatic push_res(input int addr, input logic [7:0] data);
        res_t r;
        r.addr = 10'(addr);
        r.data = data;
        res_exp.push_back(r);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_res(input int target, input string name);
        int n;
        n = 0;
        while (res_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(res_cnt), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_outs"}, 32'({win_wr_en, conv_start, res_wr_en, done}), 0);
        check({tag, "_rd_addr"}, 32'(bram_rd_addr), 0);
        check({tag, "_res_bus"}, 32'({res_wr_addr, res_wr_data, win_wr_addr, win_wr_data}), 0);
    endtask

    initial begin
        int n, base_res, base_done, base_cs, t0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; stray_done = 1'b0;
        #13;
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // First window plus a complete 26x26 pass.
        push_first_window();
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                push_res(r * 26 + c, relu(8'((r * 28 + c) % 256)));
        pulse_start();
        n = 0;
        while (done_cnt < 1 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("pass_done_seen", 32'(done_cnt), 1);
        repeat (5) @(posedge clk);
        #1;
        check("pass_done_once", 32'(done_cnt), 1);
        check("pass_write_count", 32'(res_cnt), 676);
        check("pass_queue_left", 32'(res_exp.size()), 0);
        check("pass_last_base", 32'(last_base), 725);
        check("pass_busy_after", 32'(busy), 0);
        check("win_queue_left", 32'(win_exp.size()), 0);

        // ReLU boundary values, then abort in the 4th FETCH cycle of position 2.
        base_res = res_cnt; base_done = done_cnt;
        stub_q.push_back(8'h85);
        stub_q.push_back(8'h05);
        push_res(0, relu(8'h85));
        push_res(1, 8'h05);
        pulse_start();
        wait_res(base_res + 2, "relu_writes");
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        check("busy_before_abort", 32'(busy), 1);
        @(posedge clk); #1 abort = 1'b0;
        check("abort_idle", 32'(busy), 0);
        check("abort_win_dropped", 32'(win_wr_en), 0);
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_write", 32'(res_cnt), 32'(base_res + 2));
        check("abort_no_done", 32'(done_cnt), 32'(base_done));

        // Restart after abort begins at address 0.
        begin
            win_t w;
            w.idx = 4'd0; w.rd_addr = 10'd0; w.data = 8'd0;
            win_exp.push_back(w);
        end
        push_res(0, 8'd0);
        pulse_start();
        wait_res(base_res + 3, "restart_write");
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;

        // Asynchronous reset while waiting for the engine.
        base_cs = conv_start_cnt;
        pulse_start();
        n = 0;
        while (conv_start_cnt == base_cs && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("conv_start_seen", 32'(conv_start_cnt), 32'(base_cs + 1));
        #2;
        check("wait_conv_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1 rst = 1'b0;

        // Start on the first edge after reset; stray start/done during FETCH must not disturb.
        push_first_window();
        push_res(0, relu(8'd0));
        base_res = res_cnt; base_done = done_cnt;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
        check("start_after_rst", 32'(busy), 1);
        @(posedge clk); #1 start = 1'b1; stray_done = 1'b1;
        @(posedge clk); #1 start = 1'b0; stray_done = 1'b0;
        base_cs = conv_start_cnt;
        n = 0;
        while (conv_start_cnt == base_cs && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("fetch_length", 32'(conv_start_cyc - t0), 10);
        wait_res(base_res + 1, "stray_write");
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("stray_no_done", 32'(done_cnt), 32'(base_done));
        check("final_queues", 32'(res_exp.size() + win_exp.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
